// File: rtl/a2d_pkg.sv
// Shared types and constants for the ADC128S round-robin interface.
// Holds sequencer/pointer encodings, channel numbers and SPI divider compare values.
package a2d_pkg;

  localparam int unsigned DIV_W      = 5;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned CH_W       = 3;

  localparam logic [CH_W-1:0] DEF_CH_LFT  = 3'd0;
  localparam logic [CH_W-1:0] DEF_CH_RGHT = 3'd4;
  localparam logic [CH_W-1:0] DEF_CH_BATT = 3'd5;

  localparam logic [DIV_W-1:0] DIV_LOAD   = 5'b10111;
  localparam logic [DIV_W-1:0] DIV_SAMPLE = 5'b01111;
  localparam logic [DIV_W-1:0] DIV_SHIFT  = 5'b11111;

  typedef enum logic [1:0] {IDLE, CMD, GAP, READ} seq_state_t;
  typedef enum logic [1:0] {PTR_LFT, PTR_RGHT, PTR_BATT} ptr_t;
  typedef enum logic {SPI_IDLE, SPI_ACTIVE} spi_state_t;

  // Conversion command word: channel sits in bits [13:11].
  function automatic logic [FRAME_BITS-1:0] make_cmd(input logic [CH_W-1:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  function automatic ptr_t next_ptr(input ptr_t p);
    case (p)
      PTR_LFT:  return PTR_RGHT;
      PTR_RGHT: return PTR_BATT;
      default:  return PTR_LFT;
    endcase
  endfunction

endpackage

// File: rtl/a2d_intf_spi_mstr16.sv
// One 16-bit SPI mode-3 frame: SCLK = clk/32 idling high, MISO sampled one clk
// before SCLK rises, MOSI shifted alongside the falling edge.
module spi_mstr16
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  spi_state_t         state;
  logic [DIV_W-1:0]   div;
  logic [4:0]         bit_cnt;
  logic [15:0]        tx;
  logic [15:0]        rx;
  logic               active;
  logic               sample;
  logic               shift;
  logic               last;

  assign active  = (state == SPI_ACTIVE);
  assign last    = (bit_cnt == 5'(FRAME_BITS));
  assign sample  = active && (div == DIV_SAMPLE);
  // The front-porch 11111 arrives before any sample and must not shift.
  assign shift   = active && (div == DIV_SHIFT) && (bit_cnt != 5'd0) && !last;
  assign done    = active && (div == DIV_SHIFT) && last;
  assign MOSI    = tx[15];
  assign rd_data = rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SPI_IDLE;
      div     <= DIV_LOAD;
      bit_cnt <= 5'd0;
      tx      <= 16'h0000;
      rx      <= 16'h0000;
      SS_n    <= 1'b1;
      SCLK    <= 1'b1;
    end else begin
      case (state)
        SPI_IDLE: begin
          SS_n <= 1'b1;
          SCLK <= 1'b1;
          if (wrt) begin
            state   <= SPI_ACTIVE;
            div     <= DIV_LOAD;
            bit_cnt <= 5'd0;
            tx      <= cmd;
          end
        end
        SPI_ACTIVE: begin
          div <= div + 5'd1;
          if (done) begin
            state <= SPI_IDLE;
            SS_n  <= 1'b1;
            SCLK  <= 1'b1;
          end else begin
            SS_n  <= 1'b0;
            SCLK  <= div[4];
          end
          if (sample) begin
            rx      <= {rx[14:0], MISO};
            bit_cnt <= bit_cnt + 5'd1;
          end
          if (shift) begin
            tx <= {tx[14:0], 1'b0};
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/a2d_intf.sv
// Round-robin ADC128S sequencer: each nxt runs a command frame then a read frame
// on the next channel (LFT -> RGHT -> BATT) and latches the 12-bit result.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter logic [2:0] CH_LFT  = DEF_CH_LFT,
  parameter logic [2:0] CH_RGHT = DEF_CH_RGHT,
  parameter logic [2:0] CH_BATT = DEF_CH_BATT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  seq_state_t  state;
  ptr_t        ptr;
  logic [2:0]  chnl;
  logic [15:0] cmd_c;
  logic        wrt_c;
  logic        done_c;
  logic [15:0] rd_data;
  logic [3:0]  rx_hi_unused;

  always_comb begin
    chnl = CH_LFT;
    case (ptr)
      PTR_RGHT: chnl = CH_RGHT;
      PTR_BATT: chnl = CH_BATT;
      default:  chnl = CH_LFT;
    endcase
  end

  assign cmd_c        = make_cmd(chnl);
  // Frame 1 starts on the accepted nxt; frame 2 starts out of the one-clk GAP.
  assign wrt_c        = ((state == IDLE) && nxt) || (state == GAP);
  assign rx_hi_unused = rd_data[15:12];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= PTR_LFT;
      lft_ld  <= 12'h000;
      rght_ld <= 12'h000;
      batt    <= 12'h000;
    end else begin
      case (state)
        IDLE: if (nxt) state <= CMD;
        CMD:  if (done_c) state <= GAP;
        GAP:  state <= READ;
        READ: begin
          if (done_c) begin
            state <= IDLE;
            ptr   <= next_ptr(ptr);
            case (ptr)
              PTR_RGHT: rght_ld <= rd_data[11:0];
              PTR_BATT: batt    <= rd_data[11:0];
              default:  lft_ld  <= rd_data[11:0];
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  spi_mstr16 u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt_c),
    .cmd     (cmd_c),
    .done    (done_c),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

endmodule

// File: tb/tb_a2d_intf.sv
// Scoreboarded bench for a2d_intf with a behavioural ADC128S on the SPI pins.
// Completed conversions are popped and compared by an independent monitor.
module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nxt = 1'b0;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        ss_n, sclk, mosi;
  logic        miso = 1'b0;

  int     npass = 0;
  int     ntot  = 0;
  longint cyc   = 0;

  a2d_intf dut (
    .clk     (clk),
    .rst     (rst),
    .nxt     (nxt),
    .lft_ld  (lft_ld),
    .rght_ld (rght_ld),
    .batt    (batt),
    .SS_n    (ss_n),
    .SCLK    (sclk),
    .MOSI    (mosi),
    .MISO    (miso)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- ADC128S model ----------------
  logic [11:0] adc_val [8];
  logic [3:0]  upper   = 4'h0;
  logic [2:0]  adc_ch  = 3'd0;
  logic [15:0] adc_out = 16'h0;
  logic [15:0] adc_in  = 16'h0;
  logic        ss_seen = 1'b1;
  logic [15:0] cmd_q [$];

  // Returns the channel addressed in the previous frame, MSB first after each SCLK fall.
  always @(ss_n or negedge sclk) begin
    if (!ss_n && ss_seen) begin
      adc_out = {upper, adc_val[adc_ch]};
      ss_seen = 1'b0;
    end else if (!ss_n && !sclk) begin
      miso    = adc_out[15];
      adc_out = {adc_out[14:0], 1'b0};
    end
    if (ss_n) ss_seen = 1'b1;
  end

  always @(posedge sclk or posedge ss_n) begin
    if (ss_n) begin
      cmd_q.push_back(adc_in);
      adc_ch = adc_in[13:11];
    end else begin
      adc_in = {adc_in[14:0], mosi};
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          idx;
    logic [11:0] val;
    longint      due;
    logic [2:0]  ch;
  } exp_t;

  exp_t        sb_q [$];
  logic [11:0] exp_out [3] = '{12'h0, 12'h0, 12'h0};
  logic [2:0]  chs [3]     = '{3'd0, 3'd4, 3'd5};
  int          ptr         = 0;

  task automatic issue_expect(input longint at);
    exp_t e;
    e.idx = ptr;
    e.ch  = chs[ptr];
    e.val = adc_val[chs[ptr]];
    e.due = at + 1043;
    sb_q.push_back(e);
    ptr = (ptr + 1) % 3;
  endtask

  task automatic complete();
    exp_t        e;
    logic [15:0] c;
    if (sb_q.size() == 0) begin
      ntot++;
      $display("FAIL unexpected_conv: conversion finished at cycle %0d with none outstanding", cyc);
      cmd_q.delete();
    end else begin
      e = sb_q.pop_front();
      exp_out[e.idx] = e.val;
      check("latency",   cyc,     e.due);
      check("lft_ld",    lft_ld,  exp_out[0]);
      check("rght_ld",   rght_ld, exp_out[1]);
      check("batt",      batt,    exp_out[2]);
      check("cmd_count", cmd_q.size(), 2);
      while (cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        check("cmd_word", c, {2'b00, e.ch, 11'h000});
      end
    end
  endtask

  int   frames  = 0;
  logic prev_ss = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      frames = 0;
      sb_q.delete();
      cmd_q.delete();
      exp_out = '{12'h0, 12'h0, 12'h0};
    end else if (!prev_ss && ss_n) begin
      frames++;
      if (frames % 2 == 0) complete();
    end
    prev_ss = ss_n;
  end

  // ---------------- frame timing monitor ----------------
  int     low_cnt = 0, rises = 0, falls = 0;
  longint last_fall = 0;
  bit     in_frame = 1'b0, per_bad = 1'b0;
  logic   prev_ss2 = 1'b1, prev_sclk = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (prev_ss2 && !ss_n) begin
        in_frame = 1'b1; low_cnt = 0; rises = 0; falls = 0; per_bad = 1'b0;
      end
      if (!ss_n && in_frame) begin
        low_cnt++;
        if (!prev_sclk && sclk) rises++;
        if (prev_sclk && !sclk) begin
          if (falls > 0 && (cyc - last_fall) != 32) per_bad = 1'b1;
          falls++;
          last_fall = cyc;
        end
      end
      if (!prev_ss2 && ss_n && in_frame) begin
        check("frame_len",   low_cnt, 520);
        check("sclk_rises",  rises,   16);
        check("sclk_falls",  falls,   16);
        check("sclk_period", per_bad, 0);
        check("sclk_idle",   sclk,    1);
        in_frame = 1'b0;
      end
    end
    prev_ss2  = ss_n;
    prev_sclk = sclk;
  end

  // ---------------- stimulus ----------------
  task automatic start_conv(output longint at);
    @(posedge clk); #1;
    nxt = 1'b1;
    at  = cyc + 1;
    issue_expect(at);
    @(posedge clk); #1;
    nxt = 1'b0;
  endtask

  task automatic pulse_busy();
    @(posedge clk); #1;
    nxt = 1'b1;
    @(posedge clk); #1;
    nxt = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      ntot++;
      $display("FAIL conv_timeout: %0d conversions outstanding after %0d cycles", sb_q.size(), n);
      sb_q.delete();
    end
  endtask

  task automatic check_reset_pins();
    check("rst_ss_n",    ss_n,    1);
    check("rst_sclk",    sclk,    1);
    check("rst_mosi",    mosi,    0);
    check("rst_lft_ld",  lft_ld,  0);
    check("rst_rght_ld", rght_ld, 0);
    check("rst_batt",    batt,    0);
  endtask

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    longint at;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
    adc_val[0] = 12'h1A6;
    adc_val[4] = 12'h1A0;
    adc_val[5] = 12'hC00;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_pins();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // rotation with a busy-time nxt during the RGHT conversion
    start_conv(at); wait_done();
    repeat (3) @(posedge clk);
    start_conv(at);
    repeat (198) @(posedge clk);
    pulse_busy();
    wait_done();
    repeat (3) @(posedge clk);
    start_conv(at); wait_done();

    // upper nibble must be dropped; nxt held across the return-to-IDLE clk
    upper = 4'hF;
    start_conv(at);
    while (cyc < at + 1042) begin @(posedge clk); #1; end
    nxt = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nxt = 1'b0;
    issue_expect(at + 1044);
    wait_done();

    // reset during frame 2 of a BATT conversion
    upper = 4'h3;
    adc_val[5] = 12'h5A5;
    start_conv(at);
    while (cyc < at + 700) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check_reset_pins();
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    ptr = 0;
    adc_val[0] = 12'h2B7;
    repeat (4) @(posedge clk);
    start_conv(at); wait_done();

    // randomized conversions with occasional busy pulses
    repeat (6) begin
      adc_val[0] = 12'($urandom);
      adc_val[4] = 12'($urandom);
      adc_val[5] = 12'($urandom);
      upper      = 4'($urandom);
      repeat ($urandom_range(0, 15)) @(posedge clk);
      start_conv(at);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 900)) @(posedge clk);
        pulse_busy();
      end
      wait_done();
    end

    repeat (1200) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
